// File: rtl/ram_stream_reader_pkg.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_pkg
//
// Shared definitions for the burst read engine that sits behind the
// dual-port weight/feature RAM.
//
// Contents:
//   RSR_RAM_DEPTH  - default RAM depth in words (shared with the RAM instance)
//   RSR_DATA_WIDTH - default RAM / stream word width
//   rsr_state_e    - reader FSM state encoding (IDLE / ISSUE / DRAIN)
// ---------------------------------------------------------------------------
package ram_stream_reader_pkg;

  localparam int RSR_RAM_DEPTH  = 32;
  localparam int RSR_DATA_WIDTH = 64;

  // Reader FSM. The encoding is visible on the dbg_state port, so keep the
  // values stable: IDLE=0, ISSUE=1, DRAIN=2.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rsr_state_e;

endpackage

// File: rtl/ram_stream_reader_stream_fifo2.sv
// ---------------------------------------------------------------------------
// ram_stream_reader_stream_fifo2
//
// Two-entry valid/ready buffer carrying a data word plus a last flag. It
// absorbs the RAM's one-cycle read latency so the reader can keep one read
// in flight while the consumer stalls.
//
// Handshake: a word transfers on the output on any clock edge where
// out_valid && out_ready are both high; out_valid never depends on
// out_ready, and out_data/out_last hold stable while out_valid && !out_ready.
// The input side has no ready: the producer only pushes when it has already
// reserved a slot (credit check in the parent), so a push arriving at
// count 2 without a same-cycle pop never happens.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset (flushes the buffer)
//   in_valid   - push the word on in_data/in_last this cycle
//   in_data    - word to push
//   in_last    - last-of-burst tag travelling with the word
//   out_valid  - head entry present
//   out_ready  - consumer accepts the head entry
//   out_data   - head entry data
//   out_last   - head entry last tag
//   count      - current occupancy (0..2), used for credit accounting
// ---------------------------------------------------------------------------
module ram_stream_reader_stream_fifo2
  import ram_stream_reader_pkg::*;
#(
  parameter int DATA_WIDTH = RSR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [1:0]            count
);

  // Entry 0 is always the head; entry 1 is the tail when two are held.
  logic [DATA_WIDTH-1:0] data0_q;
  logic [DATA_WIDTH-1:0] data1_q;
  logic                  last0_q;
  logic                  last1_q;
  logic [1:0]            count_q;

  logic pop;
  logic push;

  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;
  // A push at count 2 is only legal alongside a pop.
  assign push      = in_valid && ((count_q != 2'd2) || pop);

  assign out_data  = data0_q;
  assign out_last  = last0_q;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data0_q <= '0;
      data1_q <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            data0_q <= in_data;
            last0_q <= in_last;
          end else begin
            data1_q <= in_data;
            last1_q <= in_last;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          // Shift tail to head; at count 1 this copies a stale tail,
          // which is harmless because the entry becomes invalid.
          data0_q <= data1_q;
          last0_q <= last1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged; pop can only coincide with count 1 or 2.
          if (count_q == 2'd2) begin
            data0_q <= data1_q;
            last0_q <= last1_q;
            data1_q <= in_data;
            last1_q <= in_last;
          end else begin
            data0_q <= in_data;
            last0_q <= in_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/ram_stream_reader.sv
// ---------------------------------------------------------------------------
// ram_stream_reader
//
// Burst read engine. Takes a (base address, length) command, issues one
// single-cycle read per word on a RAM port, and streams the returned words
// out on a valid/ready interface with a last flag. Under no backpressure it
// sustains one word per cycle.
//
// Handshake (both cmd_* and out_*): a transfer happens on a clock edge where
// valid && ready are both high. A source never lowers valid or changes its
// payload until the transfer happens; ready may toggle freely.
//
// Ports:
//   clk        - sole clock, all state on posedge
//   rst        - synchronous active-high reset
//   cmd_valid  - command offered (ignored unless the reader is idle)
//   cmd_ready  - reader idle and out of reset
//   cmd_addr   - first word address
//   cmd_len    - burst length in words, 0..RAM_DEPTH
//   ram_en     - RAM read enable for this cycle
//   ram_addr   - RAM read address (held when ram_en is low)
//   ram_rdata  - RAM registered read data, valid the cycle after ram_en
//   out_valid  - stream word present
//   out_ready  - consumer accepts
//   out_data   - stream word
//   out_last   - final word of the burst
//   done       - one-cycle pulse once a burst has fully drained
//   dbg_state  - current FSM state (rsr_state_e encoding)
// ---------------------------------------------------------------------------
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int RAM_DEPTH  = RSR_RAM_DEPTH,
  parameter int ADDR_WIDTH = $clog2(RAM_DEPTH),
  parameter int DATA_WIDTH = RSR_DATA_WIDTH,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_en,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  done,
  output logic [1:0]            dbg_state
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

  rsr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;        // next address to issue
  logic [LEN_WIDTH-1:0]  remaining_q;   // words still to issue
  logic                  inflight_q;    // a read was issued last cycle
  logic                  inflight_last_q;
  logic                  zero_pend_q;   // zero-length command awaiting its done
  logic                  done_q;

  logic [1:0]            fifo_count;
  logic                  pop;
  logic [2:0]            occupancy;
  logic [2:0]            occupancy_limit;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] addr_next;

  // Buffer credit: words held plus the word still in the RAM pipeline must
  // stay within two entries after this cycle's pop. A pop this cycle frees
  // a slot immediately, which is what keeps full rate at steady state.
  assign pop             = out_valid && out_ready;
  assign occupancy       = {1'b0, fifo_count} + {2'b00, inflight_q};
  assign occupancy_limit = 3'd2 + {2'b00, pop};

  assign issue = (state_q == ST_ISSUE) && (remaining_q != '0)
                 && (occupancy < occupancy_limit);

  // Explicit wrap so a non-power-of-two depth still wraps at RAM_DEPTH-1.
  assign addr_next = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_ONE;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign ram_en    = issue;
  assign ram_addr  = addr_q;
  assign done      = done_q;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      zero_pend_q     <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      // The read issued now returns next cycle and is pushed then; the
      // word issued with remaining==1 carries the last tag.
      inflight_q      <= issue;
      inflight_last_q <= issue && (remaining_q == LEN_ONE);
      zero_pend_q     <= 1'b0;
      done_q          <= zero_pend_q;

      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            remaining_q <= cmd_len;
            if (cmd_len == '0) begin
              // Nothing to read: stay idle, done pulses one cycle later.
              zero_pend_q <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end

        ST_ISSUE: begin
          if (issue) begin
            addr_q      <= addr_next;
            remaining_q <= remaining_q - LEN_ONE;
            if (remaining_q == LEN_ONE) begin
              state_q <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          // The tagged word cannot reach the head before DRAIN, because
          // it is pushed one cycle after its issue moved us here.
          if (pop && out_last) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  ram_stream_reader_stream_fifo2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_stream_fifo2 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight_q),
    .in_data   (ram_rdata),
    .in_last   (inflight_last_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_ram_stream_reader
//
// Directed bench for ram_stream_reader. A behavioural RAM (word[i] = i,
// one-cycle registered read) sits on the read port. Edge numbering: T is
// the clock edge on which the command handshake happens; "k" is the number
// of edges after T, and outputs are sampled 1 time unit after each edge.
// ---------------------------------------------------------------------------
module tb_ram_stream_reader;

  localparam int RAM_DEPTH  = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 64;
  localparam int LEN_WIDTH  = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [LEN_WIDTH-1:0]  cmd_len;
  logic                  ram_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  done;
  logic [1:0]            dbg_state;

  logic [DATA_WIDTH-1:0] ram_mem [RAM_DEPTH];

  int total = 0;
  int bad   = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];

  ram_stream_reader #(
    .RAM_DEPTH  (RAM_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Behavioural RAM port: registered read.
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= ram_mem[ram_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full-rate burst; expected words are taken from exp_q.
  task automatic burst_full_rate(input string tag, input logic [ADDR_WIDTH-1:0] addr,
                                 input int len);
    logic [DATA_WIDTH-1:0] w;
    out_ready = 1'b1;
    cmd_addr  = addr;
    cmd_len   = LEN_WIDTH'(len);
    cmd_valid = 1'b1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL %s_cmd_ready got=%b exp=1", tag, cmd_ready);
    end
    step();  // edge T
    cmd_valid = 1'b0;
    total++;
    if (ram_en !== 1'b1 || ram_addr !== addr) begin
      bad++; $display("FAIL %s_first_issue got en=%b addr=%0d exp en=1 addr=%0d",
                      tag, ram_en, ram_addr, addr);
    end
    for (int k = 1; k <= len + 2; k++) begin
      step();
      if (k == 1) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL %s_early_valid k=1 got=%b exp=0", tag, out_valid);
        end
      end else if (k <= len + 1) begin
        w = exp_q.pop_front();
        total++;
        if (out_valid !== 1'b1 || out_data !== w || out_last !== (k == len + 1)) begin
          bad++; $display("FAIL %s_word k=%0d got v=%b d=%0d l=%b exp v=1 d=%0d l=%b",
                          tag, k, out_valid, out_data, out_last, w, (k == len + 1));
        end
      end else begin
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || cmd_ready !== 1'b1) begin
          bad++; $display("FAIL %s_done k=%0d got done=%b v=%b rdy=%b exp 1 0 1",
                          tag, k, done, out_valid, cmd_ready);
        end
      end
      if (k <= len + 1) begin
        total++;
        if (done !== 1'b0) begin
          bad++; $display("FAIL %s_done_early k=%0d got=%b exp=0", tag, k, done);
        end
      end
    end
    step();
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL %s_done_pulse got=%b exp=0", tag, done);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; out_ready = 1'b0; cmd_addr = '0; cmd_len = '0;
    step(); step();
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL reset_cmd_ready got=%b exp=0", cmd_ready);
    end
    total++;
    if (ram_en !== 1'b0 || ram_addr !== '0 || out_valid !== 1'b0 || out_data !== '0
        || out_last !== 1'b0 || done !== 1'b0 || dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_outputs got en=%b a=%0d v=%b d=%0d l=%b done=%b st=%0d exp all 0",
                      ram_en, ram_addr, out_valid, out_data, out_last, done, dbg_state);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    exp_q.delete();
    for (int i = 4; i <= 11; i++) exp_q.push_back(DATA_WIDTH'(i));
    burst_full_rate("basic", 5'd4, 8);
  endtask

  task automatic test_wrap();
    exp_q.delete();
    exp_q.push_back(64'd30); exp_q.push_back(64'd31); exp_q.push_back(64'd0);
    exp_q.push_back(64'd1);  exp_q.push_back(64'd2);
    burst_full_rate("wrap", 5'd30, 5);
  endtask

  task automatic test_zero_len();
    out_ready = 1'b1; cmd_addr = 5'd7; cmd_len = '0; cmd_valid = 1'b1;
    step();  // edge T
    cmd_valid = 1'b0;
    total++;
    if (done !== 1'b0 || cmd_ready !== 1'b1 || out_valid !== 1'b0 || ram_en !== 1'b0) begin
      bad++; $display("FAIL zero_k0 got done=%b rdy=%b v=%b en=%b exp 0 1 0 0",
                      done, cmd_ready, out_valid, ram_en);
    end
    step();
    total++;
    if (done !== 1'b1 || cmd_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL zero_k1 got done=%b rdy=%b v=%b exp 1 1 0", done, cmd_ready, out_valid);
    end
    step();
    total++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL zero_k2 got done=%b v=%b exp 0 0", done, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int issued = 0;
    int popped = 0;
    logic [ADDR_WIDTH-1:0] exp_addr = 5'd10;
    bit got_done = 0;
    bit hold_prev = 0;
    logic [DATA_WIDTH-1:0] prev_data = '0;
    logic [DATA_WIDTH-1:0] w;
    exp_q.delete();
    for (int i = 10; i <= 17; i++) exp_q.push_back(DATA_WIDTH'(i));
    out_ready = 1'b0; cmd_addr = 5'd10; cmd_len = 6'd8; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    for (int c = 0; c < 300 && !got_done; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (done === 1'b1) begin
        got_done = 1;
      end else begin
        if (hold_prev) begin
          total++;
          if (out_valid !== 1'b1 || out_data !== prev_data) begin
            bad++; $display("FAIL bp_hold got v=%b d=%0d exp v=1 d=%0d", out_valid, out_data, prev_data);
          end
        end
        if (ram_en === 1'b1) begin
          total++;
          if (ram_addr !== exp_addr) begin
            bad++; $display("FAIL bp_addr got=%0d exp=%0d", ram_addr, exp_addr);
          end
          exp_addr = (exp_addr == 5'd31) ? 5'd0 : exp_addr + 5'd1;
          issued++;
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
          w = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
          total++;
          if (out_data !== w || out_last !== (popped == 7)) begin
            bad++; $display("FAIL bp_word n=%0d got d=%0d l=%b exp d=%0d l=%b",
                            popped, out_data, out_last, w, (popped == 7));
          end
          popped++;
        end
        hold_prev = (out_valid === 1'b1) && (out_ready === 1'b0);
        prev_data = out_data;
        step();
        total++;
        if (issued - popped > 2) begin
          bad++; $display("FAIL bp_occupancy got=%0d exp<=2", issued - popped);
        end
      end
    end
    total++;
    if (!got_done || issued != 8 || popped != 8) begin
      bad++; $display("FAIL bp_complete got done=%0d issued=%0d popped=%0d exp 1 8 8",
                      got_done, issued, popped);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; cmd_addr = 5'd20; cmd_len = 6'd8; cmd_valid = 1'b1;
    step();  // edge T
    cmd_valid = 1'b0;
    step(); step();  // word 20 buffered, word 21 in flight
    total++;
    if (out_valid !== 1'b1 || out_data !== 64'd20) begin
      bad++; $display("FAIL rstmid_pre got v=%b d=%0d exp v=1 d=20", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if (cmd_ready !== 1'b0) begin
      bad++; $display("FAIL rstmid_ready_in_rst got=%b exp=0", cmd_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || ram_en !== 1'b0 || out_data !== '0 || out_last !== 1'b0
        || done !== 1'b0 || ram_addr !== '0) begin
      bad++; $display("FAIL rstmid_cleared got v=%b en=%b d=%0d l=%b done=%b a=%0d exp all 0",
                      out_valid, ram_en, out_data, out_last, done, ram_addr);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL rstmid_ready got=%b exp=1", cmd_ready);
    end
    exp_q.delete();
    exp_q.push_back(64'd0); exp_q.push_back(64'd1);
    burst_full_rate("rstmid_new", 5'd0, 2);
  endtask

  task automatic test_back_to_back();
    logic                  ev, el, ed;
    logic [DATA_WIDTH-1:0] ew;
    out_ready = 1'b1; cmd_addr = 5'd12; cmd_len = 6'd3; cmd_valid = 1'b1;
    step();  // edge T: first command
    // Second command offered immediately; must wait until the reader is idle.
    cmd_addr = 5'd25; cmd_len = 6'd2;
    for (int k = 1; k <= 11; k++) begin
      step();
      ev = 1'b0; el = 1'b0; ed = 1'b0; ew = '0;
      case (k)
        2:  begin ev = 1'b1; ew = 64'd12; end
        3:  begin ev = 1'b1; ew = 64'd13; end
        4:  begin ev = 1'b1; ew = 64'd14; el = 1'b1; end
        5:  ed = 1'b1;
        8:  begin ev = 1'b1; ew = 64'd25; end
        9:  begin ev = 1'b1; ew = 64'd26; el = 1'b1; end
        10: ed = 1'b1;
        default: begin end
      endcase
      total++;
      if (out_valid !== ev || done !== ed) begin
        bad++; $display("FAIL b2b_ctrl k=%0d got v=%b done=%b exp v=%b done=%b",
                        k, out_valid, done, ev, ed);
      end
      if (ev) begin
        total++;
        if (out_data !== ew || out_last !== el) begin
          bad++; $display("FAIL b2b_word k=%0d got d=%0d l=%b exp d=%0d l=%b",
                          k, out_data, out_last, ew, el);
        end
      end
      if (k == 5) begin
        total++;
        if (cmd_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_ready k=5 got=%b exp=1", cmd_ready);
        end
      end
      if (k == 6) cmd_valid = 1'b0;  // second command accepted on edge T+6
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) ram_mem[i] = DATA_WIDTH'(i);
    rst = 1'b1; cmd_valid = 1'b0; out_ready = 1'b0; cmd_addr = '0; cmd_len = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
